// File: rtl/mem_access_unit.sv
// RV32I load/store/fetch access unit: formats byte/half/word accesses onto a
// synchronous-read RAM or a variable-latency I/O port and reports faults.
module mem_access_unit #(
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] IO_BASE    = 32'h0000_2000,
  parameter int          IO_TIMEOUT = 255,
  localparam int         RAW        = $clog2(RAM_WORDS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            IorD,
  input  logic [2:0]      funct3,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            busy,
  output logic            done,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic            ram_en,
  output logic [3:0]      ram_we,
  output logic [RAW-1:0]  ram_addr,
  output logic [31:0]     ram_wdata,
  input  logic [31:0]     ram_rdata,
  output logic            io_en,
  output logic            io_we,
  output logic [31:0]     io_addr,
  output logic [31:0]     io_wdata,
  input  logic [31:0]     io_rdata,
  input  logic            io_ready,
  output logic [2:0]      state_dbg
);

  // Handshake: a request (MemRead|MemWrite) is taken only while busy is low;
  // it completes with exactly one done pulse, after which busy falls and the
  // next request may be presented. Requests seen while busy are dropped.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCESS  = 3'd1,
    S_RD_CAP  = 3'd2,
    S_IO_WAIT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  addr_lo_q;
  logic [2:0]  f3_q;
  logic        wr_q;
  logic [7:0]  io_cnt;

  logic        req_wr;
  logic [2:0]  eff_f3;
  logic        is_io;
  logic        illegal;
  logic        misaligned;
  logic [3:0]  st_we;
  logic [31:0] st_wd;
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;
  assign req_wr    = MemWrite;
  // Instruction fetches are always whole-word reads regardless of funct3.
  assign eff_f3    = IorD ? funct3 : 3'b010;
  assign is_io     = (addr >= IO_BASE);

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (req_wr) illegal = (eff_f3 >= 3'b011);
    else        illegal = (eff_f3 == 3'b011) || (eff_f3[2:1] == 2'b11);
    if (is_io && (eff_f3 != 3'b010)) illegal = 1'b1;
    if (eff_f3[1:0] == 2'b01 && addr[0])           misaligned = 1'b1;
    if (eff_f3[1:0] == 2'b10 && addr[1:0] != 2'b00) misaligned = 1'b1;
  end

  always_comb begin
    st_we = 4'b1111;
    st_wd = wdata;
    case (eff_f3[1:0])
      2'b00: begin
        st_we = 4'b0001 << addr[1:0];
        st_wd = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_we = 4'b0011 << {addr[1], 1'b0};
        st_wd = {2{wdata[15:0]}};
      end
      default: begin
        st_we = 4'b1111;
        st_wd = wdata;
      end
    endcase
  end

  always_comb begin
    ld_shift = ram_rdata >> {addr_lo_q, 3'b000};
    ld_data  = ram_rdata;
    case (f3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_data = {24'd0, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_data = {16'd0, ld_shift[15:0]};
      default: ld_data = ram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      addr_lo_q  <= 2'b00;
      f3_q       <= 3'b000;
      wr_q       <= 1'b0;
      io_cnt     <= 8'd0;
      rdata      <= 32'd0;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      ram_en     <= 1'b0;
      ram_we     <= 4'b0000;
      ram_addr   <= '0;
      ram_wdata  <= 32'd0;
      io_en      <= 1'b0;
      io_we      <= 1'b0;
      io_addr    <= 32'd0;
      io_wdata   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (MemWrite || MemRead) begin
            addr_lo_q <= addr[1:0];
            f3_q      <= eff_f3;
            wr_q      <= req_wr;
            if (illegal || misaligned) begin
              done       <= 1'b1;
              fault      <= 1'b1;
              fault_code <= illegal ? 2'b10 : 2'b01;
              state      <= S_DONE;
            end else if (is_io) begin
              io_en    <= 1'b1;
              io_we    <= req_wr;
              io_addr  <= addr;
              io_wdata <= wdata;
              io_cnt   <= 8'd0;
              state    <= S_IO_WAIT;
            end else begin
              ram_en    <= 1'b1;
              ram_we    <= req_wr ? st_we : 4'b0000;
              ram_addr  <= addr[RAW+1:2];
              ram_wdata <= st_wd;
              state     <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          ram_en <= 1'b0;
          ram_we <= 4'b0000;
          if (wr_q) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_RD_CAP;
          end
        end
        S_RD_CAP: begin
          rdata <= ld_data;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_IO_WAIT: begin
          if (io_ready) begin
            if (!wr_q) rdata <= io_rdata;
            io_en <= 1'b0;
            io_we <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (io_cnt == 8'(IO_TIMEOUT - 1)) begin
            io_en      <= 1'b0;
            io_we      <= 1'b0;
            done       <= 1'b1;
            fault      <= 1'b1;
            fault_code <= 2'b11;
            state      <= S_DONE;
          end else begin
            io_cnt <= io_cnt + 8'd1;
          end
        end
        S_DONE: begin
          done       <= 1'b0;
          fault      <= 1'b0;
          fault_code <= 2'b00;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: behavioural RAM and I/O responder,
// hand-computed expectations for latency, strobes, load formatting and faults.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, IorD;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        busy, done, fault;
  logic [1:0]  fault_code;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        io_en, io_we;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic        io_ready;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // observations from the last access
  int          obs_lat;
  logic        obs_ram_en, obs_io_en, obs_busy1, obs_fault, obs_io_we1;
  logic [1:0]  obs_code;
  logic [3:0]  obs_we1;
  logic [31:0] obs_wd1, obs_io_addr1, obs_io_wd1;
  logic [9:0]  obs_ra1;

  logic [31:0] mem [0:1023];
  int          io_lat = 1000;
  int          io_cnt_tb = 0;

  // clock/reset block
  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .IorD(IorD), .funct3(funct3), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .fault(fault),
    .fault_code(fault_code), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .io_en(io_en), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ready(io_ready), .state_dbg(state_dbg)
  );

  // synchronous-read RAM with byte enables
  always @(posedge clk) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  // I/O responder: io_ready rises in the io_lat-th cycle of io_en
  always @(negedge clk) begin
    if (io_en) io_cnt_tb = io_cnt_tb + 1;
    else       io_cnt_tb = 0;
    io_ready = io_en && (io_cnt_tb == io_lat);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: present a request for one cycle (cycle T)
  task automatic req(input logic wr, input logic rd, input logic iord,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    MemWrite = wr; MemRead = rd; IorD = iord; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  // monitor: sample each following cycle at negedge until done or budget
  task automatic wait_done(input int budget);
    obs_lat = -1; obs_ram_en = 1'b0; obs_io_en = 1'b0; obs_fault = 1'b0;
    obs_code = 2'b00;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (ram_en) obs_ram_en = 1'b1;
      if (io_en)  obs_io_en  = 1'b1;
      if (k == 1) begin
        obs_busy1 = busy; obs_we1 = ram_we; obs_wd1 = ram_wdata; obs_ra1 = ram_addr;
        obs_io_we1 = io_we; obs_io_addr1 = io_addr; obs_io_wd1 = io_wdata;
      end
      if (done) begin
        obs_lat = k; obs_fault = fault; obs_code = fault_code;
        break;
      end
    end
  endtask

  task automatic access(input logic wr, input logic rd, input logic iord,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int budget);
    req(wr, rd, iord, f3, a, wd);
    wait_done(budget);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[2] = 32'hCAFE_F00D;
    io_rdata = 32'h1234_5678;
    io_ready = 1'b0;
    ram_rdata = 32'd0;
    MemRead = 0; MemWrite = 0; IorD = 1; funct3 = 0; addr = 0; wdata = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_code", 32'(fault_code), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_io_en", 32'(io_en), 32'd0);

    // SW 0x10 then LW 0x10
    access(1, 0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, 20);
    check("sw_busy1", 32'(obs_busy1), 32'd1);
    check("sw_we", 32'(obs_we1), 32'hF);
    check("sw_ram_addr", 32'(obs_ra1), 32'd4);
    check("sw_lat", 32'(obs_lat), 32'd2);
    check("sw_fault", 32'(obs_fault), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    access(0, 1, 1, 3'b010, 32'h10, 32'd0, 20);
    check("lw_lat", 32'(obs_lat), 32'd3);
    check("lw_rdata", rdata, 32'hDEAD_BEEF);

    // SB 0x13, then signed/unsigned byte and half loads
    access(1, 0, 1, 3'b000, 32'h13, 32'h0000_00A5, 20);
    check("sb_we", 32'(obs_we1), 32'h8);
    check("sb_wdata", obs_wd1, 32'hA5A5_A5A5);
    check("sb_lat", 32'(obs_lat), 32'd2);
    access(0, 1, 1, 3'b000, 32'h13, 32'd0, 20);
    check("lb_rdata", rdata, 32'hFFFF_FFA5);
    access(0, 1, 1, 3'b100, 32'h13, 32'd0, 20);
    check("lbu_rdata", rdata, 32'h0000_00A5);
    access(0, 1, 1, 3'b001, 32'h12, 32'd0, 20);
    check("lh_rdata", rdata, 32'hFFFF_A5AD);
    access(0, 1, 1, 3'b101, 32'h12, 32'd0, 20);
    check("lhu_rdata", rdata, 32'h0000_A5AD);

    // misaligned half, illegal width (illegal wins over misaligned)
    access(0, 1, 1, 3'b001, 32'h11, 32'd0, 20);
    check("mis_lat", 32'(obs_lat), 32'd1);
    check("mis_fault", 32'(obs_fault), 32'd1);
    check("mis_code", 32'(obs_code), 32'd1);
    check("mis_ram_en", 32'(obs_ram_en), 32'd0);
    check("mis_rdata", rdata, 32'h0000_A5AD);
    access(0, 1, 1, 3'b011, 32'h11, 32'd0, 20);
    check("ill_code", 32'(obs_code), 32'd2);
    check("ill_fault", 32'(obs_fault), 32'd1);
    check("ill_ram_en", 32'(obs_ram_en), 32'd0);

    // SH to upper half of word 5, read whole word back
    access(1, 0, 1, 3'b001, 32'h16, 32'h0000_BEEF, 20);
    check("sh_we", 32'(obs_we1), 32'hC);
    check("sh_wdata", obs_wd1, 32'hBEEF_BEEF);
    access(0, 1, 1, 3'b010, 32'h14, 32'd0, 20);
    check("sh_rdback", rdata, 32'hBEEF_0000);

    // instruction fetch ignores funct3
    access(0, 1, 0, 3'b101, 32'h8, 32'd0, 20);
    check("fetch_lat", 32'(obs_lat), 32'd3);
    check("fetch_fault", 32'(obs_fault), 32'd0);
    check("fetch_rdata", rdata, 32'hCAFE_F00D);

    // MemRead and MemWrite both high: write wins
    access(1, 1, 1, 3'b010, 32'h20, 32'h1122_3344, 20);
    check("both_we", 32'(obs_we1), 32'hF);
    check("both_lat", 32'(obs_lat), 32'd2);
    access(0, 1, 1, 3'b010, 32'h20, 32'd0, 20);
    check("both_rdback", rdata, 32'h1122_3344);

    // I/O read with io_ready in T+4
    io_lat = 4;
    access(0, 1, 1, 3'b010, 32'h2004, 32'd0, 40);
    check("io_addr", obs_io_addr1, 32'h2004);
    check("io_we", 32'(obs_io_we1), 32'd0);
    check("io_lat", 32'(obs_lat), 32'd5);
    check("io_fault", 32'(obs_fault), 32'd0);
    check("io_rdata", rdata, 32'h1234_5678);

    // I/O timeout
    io_lat = 1000;
    access(0, 1, 1, 3'b010, 32'h2004, 32'd0, 300);
    check("to_lat", 32'(obs_lat), 32'd256);
    check("to_code", 32'(obs_code), 32'd3);
    check("to_fault", 32'(obs_fault), 32'd1);
    check("to_rdata", rdata, 32'h1234_5678);

    // I/O byte access is illegal; I/O word store
    access(1, 0, 1, 3'b000, 32'h2004, 32'd0, 20);
    check("io_sb_code", 32'(obs_code), 32'd2);
    check("io_sb_io_en", 32'(obs_io_en), 32'd0);
    io_lat = 2;
    access(1, 0, 1, 3'b010, 32'h2008, 32'hA0B0_C0D0, 40);
    check("io_sw_we", 32'(obs_io_we1), 32'd1);
    check("io_sw_wdata", obs_io_wd1, 32'hA0B0_C0D0);
    check("io_sw_lat", 32'(obs_lat), 32'd3);
    check("io_sw_rdata", rdata, 32'h1234_5678);

    // reset in T+1 of a RAM read, then a fresh read in T+3
    req(0, 1, 1, 3'b010, 32'h10, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    access(0, 1, 1, 3'b010, 32'h10, 32'd0, 20);
    check("post_rst_lat", 32'(obs_lat), 32'd3);
    check("post_rst_rdata", rdata, 32'hA5AD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
